dff_bit_packer: RTL and testbench
=================================

// Module: dff_bit_packer
// PURPOSE
//  Downstream consumer of the single-bit DFF stage. Samples the registered serial bit
//  whenever its qualifying strobe is high and packs WIDTH bits into a parallel word.
//  Presents each word on a valid/ready output port and keeps one spare word of buffering
//  so the serial side keeps filling while the output stalls. Drops bits and flags
//  overflow when both word slots are occupied.
// PARAMETERS
//  WIDTH      8  bits per packed word; legal range 2..32
//  MSB_FIRST  1  1: first received bit lands in m_data[WIDTH-1]; 0: lands in m_data[0]
// PORTS
//  clk      in   1      single clock, rising edge
//  rst      in   1      asynchronous, active-high reset
//  bit_in   in   1      serial data bit (registered DFF output)
//  bit_vld  in   1      bit_in is valid this cycle; one bit is consumed per high cycle
//  m_data   out  WIDTH  packed word
//  m_valid  out  1      m_data holds a word
//  m_ready  in   1      consumer accepts m_data when m_valid && m_ready
//  ovf      out  1      sticky flag: at least one bit was dropped
//  ovf_clr  in   1      synchronous clear of ovf
//  fill_cnt out  CNT_W  bits currently held in the shift register (0..WIDTH)
// BEHAVIOUR
//  - rst high, any time: shift_q=0, fill_cnt=0, state=FILL, m_data=0, m_valid=0, ovf=0.
//    A partial word is discarded. The first word after reset begins with the next bit_vld.
//  - Shift on bit_vld in FILL:
//      MSB_FIRST=1: shift_q <= {shift_q[WIDTH-2:0], bit_in}
//      MSB_FIRST=0: shift_q <= {bit_in, shift_q[WIDTH-1:1]}
//    fill_cnt increments by 1 on each shift.
//  - Word complete = bit_vld && fill_cnt==WIDTH-1 (the WIDTH-th bit).
//  - Output slot is free when !m_valid || m_ready.
//  - State FILL, word complete, slot free:
//      m_data <= assembled word including this bit; m_valid <= 1; fill_cnt <= 0.
//      Latency: m_valid is high on the cycle after the edge that samples the last bit.
//  - State FILL, word complete, slot busy:
//      shift_q holds the word; fill_cnt <= WIDTH; state -> FULL.
//  - State FULL, on the cycle where m_valid && m_ready:
//      m_data <= shift_q; m_valid stays 1; fill_cnt <= 0; state -> FILL.
//      A bit_vld in this same cycle is dropped; the slot frees only on the next cycle.
//  - State FULL, bit_vld high: bit discarded; ovf <= 1.
//  - Output handshake with no new word: m_valid <= 0 after m_valid && m_ready.
//  - Output handshake and word complete in the same cycle: the new word loads;
//    m_valid stays 1 with no bubble.
//  - m_data and m_valid must not change while m_valid && !m_ready, except under rst.
//  - ovf_clr clears ovf on the next edge. If an overflow occurs in the same cycle,
//    set wins and ovf stays 1.
//  - Throughput: one bit per clock sustained. A word every WIDTH cycles with m_ready
//    held high never overflows.
// STRUCTURE
//  - dff_pkg holds:
//      typedef enum logic {FILL, FULL} packer_state_t;
//      localparam/function CNT_W = $clog2(WIDTH+1).
//  - Single module with no sub-module. The shift register, output register and 2-state
//    FSM sit in one always_ff with async rst; next-state logic is in one always_comb.
// TESTING (WIDTH=8 unless noted)
//  - MSB_FIRST=1, m_ready=1, bits 1,1,0,0,0,0,0,0 on consecutive cycles -> m_data=8'hC0,
//    m_valid high exactly 1 cycle, 1 cycle after the 8th bit.
//  - MSB_FIRST=0, same bits -> m_data=8'h03.
//  - Irregular bit_vld with random gaps, bits of 8'hA5 MSB-first -> m_data=8'hA5;
//    fill_cnt tracks 1..7, then 0.
//  - m_ready=0, send 16 bits (8'h12 then 8'h34) -> m_data=8'h12 held stable, fill_cnt=8,
//    FULL. 17th bit -> ovf=1, bit dropped. Raise m_ready -> 8'h12 then 8'h34 delivered in
//    order, m_valid drops after the second handshake.
//  - 5 bits in, assert rst mid-cycle (async) -> fill_cnt=0, m_valid=0, ovf=0 immediately;
//    after release, 8 bits of 8'hF0 -> m_data=8'hF0 with no stale bits.
//  - ovf=1, pulse ovf_clr alone -> ovf=0. Pulse ovf_clr in the same cycle as a dropped
//    bit -> ovf stays 1.

Source files
------------

// File: rtl/dff_pkg.sv
// Shared types and helpers for the serial-to-parallel bit packer.
//   packer_state_t : two-state packer FSM encoding
//   cnt_width()    : width of a counter that must hold 0..width inclusive
package dff_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } packer_state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/dff_bit_packer.sv
// Packs the registered serial bit stream from the DFF stage into WIDTH-bit
// words and presents them on a valid/ready port. The shift register doubles
// as a spare word slot, so the serial side can complete one more word while
// the output stalls. Bits that arrive while both slots are occupied are
// dropped, and the sticky ovf flag is raised.
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   bit_in   : serial data bit
//   bit_vld  : bit_in is consumed on this cycle
//   m_data   : packed output word
//   m_valid  : m_data holds a word
//   m_ready  : consumer accepts m_data when m_valid && m_ready
//   ovf      : sticky flag, at least one bit was dropped
//   ovf_clr  : synchronous clear of ovf (a same-cycle drop wins)
//   fill_cnt : bits currently held in the shift register (0..WIDTH)
//
// State | Meaning
// ------+---------------------------------------------------------------
// FILL  | shift register accepting bits, fill_cnt in 0..WIDTH-1
// FULL  | shift register holds a complete word waiting for the output slot
module dff_bit_packer
    import dff_pkg::*;
#(
    parameter int  WIDTH     = 8,
    parameter bit  MSB_FIRST = 1'b1,
    localparam int CNT_W     = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_vld,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             ovf,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] fill_cnt
);

    packer_state_t    state_q, state_n;
    logic [WIDTH-1:0] shift_q, shift_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [WIDTH-1:0] data_q, data_n;
    logic             valid_q, valid_n;
    logic             ovf_q, ovf_n;

    logic [WIDTH-1:0] shifted;
    logic             handshake;
    logic             slot_free;
    logic             last_bit;

    if (MSB_FIRST) begin : g_msb_first
        assign shifted = {shift_q[WIDTH-2:0], bit_in};
    end else begin : g_lsb_first
        assign shifted = {bit_in, shift_q[WIDTH-1:1]};
    end

    assign handshake = valid_q && m_ready;
    assign slot_free = !valid_q || m_ready;
    assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_n = state_q;
        shift_n = shift_q;
        cnt_n   = cnt_q;
        data_n  = data_q;
        valid_n = valid_q;
        ovf_n   = ovf_q && !ovf_clr;

        // A handshake empties the output slot unless a new word is loaded below.
        if (handshake) begin
            valid_n = 1'b0;
        end

        case (state_q)
            FILL: begin
                if (bit_vld) begin
                    shift_n = shifted;
                    if (last_bit) begin
                        if (slot_free) begin
                            data_n  = shifted;
                            valid_n = 1'b1;
                            cnt_n   = '0;
                        end else begin
                            // Completed word parks in the shift register.
                            cnt_n   = CNT_W'(WIDTH);
                            state_n = FULL;
                        end
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
            end
            FULL: begin
                // Even on the handshake cycle the shift register is still
                // occupied, so an incoming bit is dropped.
                if (bit_vld) begin
                    ovf_n = 1'b1;
                end
                if (handshake) begin
                    data_n  = shift_q;
                    valid_n = 1'b1;
                    cnt_n   = '0;
                    state_n = FILL;
                end
            end
            default: state_n = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            shift_q <= shift_n;
            cnt_q   <= cnt_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            ovf_q   <= ovf_n;
        end
    end

    assign m_data   = data_q;
    assign m_valid  = valid_q;
    assign ovf      = ovf_q;
    assign fill_cnt = cnt_q;

endmodule

// File: tb/tb_dff_bit_packer.sv
// Directed bench for dff_bit_packer. Two instances share all inputs: one
// packs MSB-first, the other LSB-first.
module tb_dff_bit_packer;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic       bit_vld;
    logic       m_ready;
    logic       ovf_clr;

    logic [7:0] m_data;
    logic       m_valid;
    logic       ovf;
    logic [3:0] fill_cnt;

    logic [7:0] l_data;
    logic       l_valid;
    logic       l_ovf;
    logic [3:0] l_fill_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    dff_bit_packer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk      (clk),
        .rst      (rst),
        .bit_in   (bit_in),
        .bit_vld  (bit_vld),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr),
        .fill_cnt (fill_cnt)
    );

    dff_bit_packer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk      (clk),
        .rst      (rst),
        .bit_in   (bit_in),
        .bit_vld  (bit_vld),
        .m_data   (l_data),
        .m_valid  (l_valid),
        .m_ready  (m_ready),
        .ovf      (l_ovf),
        .ovf_clr  (ovf_clr),
        .fill_cnt (l_fill_cnt)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic send(input logic b);
        bit_in  = b;
        bit_vld = 1'b1;
        @(posedge clk);
        #1;
        bit_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send(w[i]);
    endtask

    task automatic test_reset;
        rst = 1'b1; bit_in = 1'b0; bit_vld = 1'b0; m_ready = 1'b1; ovf_clr = 1'b0;
        idle(2);
        tests_run++;
        if (m_valid !== 1'b0 || m_data !== 8'h00 || ovf !== 1'b0 || fill_cnt !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset: valid=%b data=%h ovf=%b fill=%0d, want 0/00/0/0",
                     m_valid, m_data, ovf, fill_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_msb_lsb;
        logic [7:0] w;
        w = 8'b1100_0000;
        m_ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            send(w[i]);
            if (i != 0) begin
                tests_run++;
                if (m_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL early_valid: bit %0d valid=%b want 0", 7 - i, m_valid);
                end
            end
        end
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== 8'hC0) begin
            tests_failed++;
            $display("FAIL msb_first: valid=%b data=%h want 1/c0", m_valid, m_data);
        end
        tests_run++;
        if (l_valid !== 1'b1 || l_data !== 8'h03) begin
            tests_failed++;
            $display("FAIL lsb_first: valid=%b data=%h want 1/03", l_valid, l_data);
        end
        idle(1);
        tests_run++;
        if (m_valid !== 1'b0 || l_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL one_cycle_valid: msb=%b lsb=%b want 0/0", m_valid, l_valid);
        end
    endtask

    task automatic test_gaps;
        logic [7:0] w;
        int gaps [8] = '{0, 2, 1, 3, 0, 1, 4, 2};
        w = 8'hA5;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            idle(gaps[i]);
            send(w[7 - i]);
            tests_run++;
            if (fill_cnt !== 4'((i + 1) % 8)) begin
                tests_failed++;
                $display("FAIL gap_fill: bit %0d fill=%0d want %0d", i, fill_cnt, (i + 1) % 8);
            end
        end
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== 8'hA5 || l_data !== 8'hA5) begin
            tests_failed++;
            $display("FAIL gap_word: valid=%b msb=%h lsb=%h want 1/a5/a5", m_valid, m_data, l_data);
        end
        idle(1);
    endtask

    task automatic test_stall;
        logic [7:0] w;
        m_ready = 1'b0;
        send_word(8'h12);
        w = 8'h34;
        for (int i = 7; i >= 0; i--) begin
            send(w[i]);
            tests_run++;
            if (m_valid !== 1'b1 || m_data !== 8'h12) begin
                tests_failed++;
                $display("FAIL stall_hold: valid=%b data=%h want 1/12", m_valid, m_data);
            end
        end
        tests_run++;
        if (fill_cnt !== 4'd8 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_full: fill=%0d ovf=%b want 8/0", fill_cnt, ovf);
        end
        send(1'b1);
        tests_run++;
        if (ovf !== 1'b1 || fill_cnt !== 4'd8 || m_data !== 8'h12) begin
            tests_failed++;
            $display("FAIL stall_ovf: ovf=%b fill=%0d data=%h want 1/8/12", ovf, fill_cnt, m_data);
        end
        m_ready = 1'b1;
        idle(1);
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== 8'h34 || fill_cnt !== 4'd0) begin
            tests_failed++;
            $display("FAIL stall_second: valid=%b data=%h fill=%0d want 1/34/0", m_valid, m_data, fill_cnt);
        end
        idle(1);
        tests_run++;
        if (m_valid !== 1'b0 || ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_drain: valid=%b ovf=%b want 0/1", m_valid, ovf);
        end
    endtask

    task automatic test_ovf_clr;
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        tests_run++;
        if (ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_clr: ovf=%b want 0", ovf);
        end
        m_ready = 1'b0;
        send_word(8'h00);
        send_word(8'hFF);
        send(1'b0);
        tests_run++;
        if (ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_set: ovf=%b want 1", ovf);
        end
        ovf_clr = 1'b1;
        send(1'b1);
        ovf_clr = 1'b0;
        tests_run++;
        if (ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_set_wins: ovf=%b want 1", ovf);
        end
        m_ready = 1'b1;
        idle(1);
        m_ready = 1'b0;
        idle(1);
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== 8'hFF) begin
            tests_failed++;
            $display("FAIL ovf_drain: valid=%b data=%h want 1/ff", m_valid, m_data);
        end
    endtask

    task automatic test_async_reset;
        logic [7:0] w;
        w = 8'b1011_0000;
        for (int i = 7; i >= 3; i--) send(w[i]);
        tests_run++;
        if (fill_cnt !== 4'd5 || m_valid !== 1'b1 || ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset: fill=%0d valid=%b ovf=%b want 5/1/1", fill_cnt, m_valid, ovf);
        end
        #3;
        rst = 1'b1;
        #1;
        tests_run++;
        if (fill_cnt !== 4'd0 || m_valid !== 1'b0 || ovf !== 1'b0 || m_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL async_reset: fill=%0d valid=%b ovf=%b data=%h want 0/0/0/00",
                     fill_cnt, m_valid, ovf, m_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        send_word(8'hF0);
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== 8'hF0 || l_data !== 8'h0F) begin
            tests_failed++;
            $display("FAIL post_reset_word: valid=%b msb=%h lsb=%h want 1/f0/0f", m_valid, m_data, l_data);
        end
        idle(1);
    endtask

    task automatic test_hs_and_complete;
        logic [7:0] w;
        m_ready = 1'b0;
        send_word(8'h11);
        w = 8'h22;
        for (int i = 7; i >= 1; i--) send(w[i]);
        tests_run++;
        if (m_data !== 8'h11 || fill_cnt !== 4'd7) begin
            tests_failed++;
            $display("FAIL hs_pre: data=%h fill=%0d want 11/7", m_data, fill_cnt);
        end
        m_ready = 1'b1;
        send(w[0]);
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== 8'h22 || fill_cnt !== 4'd0) begin
            tests_failed++;
            $display("FAIL hs_no_bubble: valid=%b data=%h fill=%0d want 1/22/0", m_valid, m_data, fill_cnt);
        end
        idle(1);
        tests_run++;
        if (m_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL hs_drain: valid=%b want 0", m_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] words [3] = '{8'h5A, 8'hC3, 8'h81};
        logic [7:0] w;
        m_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            w = words[k / 8];
            send(w[7 - (k % 8)]);
            tests_run++;
            if (k % 8 == 7) begin
                if (m_valid !== 1'b1 || m_data !== w) begin
                    tests_failed++;
                    $display("FAIL b2b_word: k=%0d valid=%b data=%h want 1/%h", k, m_valid, m_data, w);
                end
            end else if (m_valid !== 1'b0 || fill_cnt !== 4'((k + 1) % 8)) begin
                tests_failed++;
                $display("FAIL b2b_fill: k=%0d valid=%b fill=%0d want 0/%0d", k, m_valid, fill_cnt, (k + 1) % 8);
            end
        end
        idle(1);
        tests_run++;
        if (ovf !== 1'b0 || m_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_ovf: ovf=%b valid=%b want 0/0", ovf, m_valid);
        end
    endtask

    initial begin
        test_reset();
        test_msb_lsb();
        test_gaps();
        test_stall();
        test_ovf_clr();
        test_async_reset();
        test_hs_and_complete();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
